mul_operand_sequencer: RTL



---
 rtl/mul_seq_pkg.sv | 21 ++
 rtl/op_pair_fifo.sv | 69 ++++++
 rtl/mul_operand_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
//   Shared definitions for the multiplier operand sequencer: sequencer state
//   encoding, the default operand/product width, and the operand-pair type.
package mul_seq_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT,
    OUT
  } seq_state_t;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] a;
    logic [WIDTH_DEFAULT-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/op_pair_fifo.sv
// op_pair_fifo
//   Synchronous FIFO of operand pairs {a, b}. Full/empty come from an entry
//   counter. A push while full is accepted only when a pop happens in the
//   same cycle. Storage is not reset; only pointers and count are.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_a/b    write request and pair to store
//   pop               read request (head advances on this edge)
//   head_a/head_b     pair at the head of the queue (valid when !empty)
//   full, empty       occupancy flags from the registered count
module op_pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  input  logic             pop,
  output logic [WIDTH-1:0] head_a,
  output logic [WIDTH-1:0] head_b,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_a  = mem_a[rd_ptr];
  assign head_b  = mem_b[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_a[wr_ptr] <= push_a;
      mem_b[wr_ptr] <= push_b;
    end
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Feeds a repeated-addition multiplier from a valid/ready stream of operand
//   pairs. Pairs are queued in op_pair_fifo, serially loaded into the
//   multiplier (start high for two cycles: A then B), the product is
//   captured on done and returned on a valid/ready output stream. A job whose
//   done never arrives within TIMEOUT_CYCLES is dropped and timeout_err set.
//
// Build option:
//   ZERO_BYPASS_EN  when defined, a popped pair with a zero operand skips the
//                   multiplier and goes straight to OUT with product 0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b  operand pair input stream
//   mul_start, mul_data_in       multiplier load protocol (A, then B)
//   mul_done, mul_product        multiplier completion and product register
//   out_valid/out_ready/out_product  product output stream
//   busy                         job in flight or pairs queued
//   timeout_err                  sticky; set when a job is aborted
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEFAULT,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_data_in,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             zero_pair;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;

  // A new job is taken from the queue either from IDLE or directly at the
  // end of an accepted OUT, so back-to-back jobs lose no cycle.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == OUT) && out_ready));

`ifdef ZERO_BYPASS_EN
  assign zero_pair = (head_a == '0) || (head_b == '0);
`else
  assign zero_pair = 1'b0;
`endif

  op_pair_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .push_a (in_a),
    .push_b (in_b),
    .pop    (pop),
    .head_a (head_a),
    .head_b (head_b),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // B is needed one cycle after the pop; A goes straight to mul_data_in.
  always_ff @(posedge clk) begin
    if (pop) b_r <= head_b;
  end

  // Outputs are registered: each transition sets the values seen in the
  // destination state. mul_start can only be high in LOAD_A/LOAD_B, which
  // keeps the unreset multiplier idle until a real job is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mul_start   <= 1'b0;
      mul_data_in <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (zero_pair) begin
              state       <= OUT;
              out_valid   <= 1'b1;
              out_product <= '0;
            end else begin
              state       <= LOAD_A;
              mul_start   <= 1'b1;
              mul_data_in <= head_a;
            end
          end
        end
        LOAD_A: begin
          state       <= LOAD_B;
          mul_start   <= 1'b1;
          mul_data_in <= b_r;
        end
        LOAD_B: begin
          state     <= WAIT;
          mul_start <= 1'b0;
          tmo_cnt   <= '0;
        end
        WAIT: begin
          // done is only honoured here; a level left over from the previous
          // job while loading is ignored.
          if (mul_done) begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_product <= mul_product;
          end else if (tmo_cnt == CNT_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            if (pop) begin
              if (zero_pair) begin
                state       <= OUT;
                out_valid   <= 1'b1;
                out_product <= '0;
              end else begin
                state       <= LOAD_A;
                mul_start   <= 1'b1;
                mul_data_in <= head_a;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
